// File: rtl/shader_pkg.sv
// Shared types and constants for the shader-array frame scheduler.
package shader_pkg;

  localparam int VOX_COORD_W  = 8;
  localparam int VOX_ID_W     = 8;
  localparam int SHADE_PERIOD = 2;
  localparam int READ_LATENCY = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_R_FETCH,
    ST_RASTER,
    ST_S_FETCH,
    ST_SHADE,
    ST_READOUT,
    ST_DONE
  } sched_state_e;

  typedef struct packed {
    logic [VOX_COORD_W-1:0] x;
    logic [VOX_COORD_W-1:0] y;
    logic [VOX_COORD_W-1:0] z;
    logic [VOX_ID_W-1:0]    id;
  } voxel_t;

endpackage

// File: rtl/shader_scheduler_bcast.sv
// Two-stage holding register: memory data lands in the prefetch stage and
// moves to the broadcast stage on advance, so the next item is ready at once.
module bcast_prefetch #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         capture,
  input  logic         to_bcast,
  input  logic         advance,
  input  logic [W-1:0] d,
  output logic [W-1:0] bcast
);

  logic [W-1:0] pre;

  // Data arriving on the same edge as an advance bypasses the prefetch stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre   <= '0;
      bcast <= '0;
    end else begin
      if (advance) begin
        bcast <= capture ? d : pre;
      end else if (capture && to_bcast) begin
        bcast <= d;
      end
      if (capture && !to_bcast && !advance) begin
        pre <= d;
      end
    end
  end

endmodule

// File: rtl/shader_scheduler.sv
// Frame sequencer: broadcasts voxels for rasterization, palette entries for
// shading, then scans the shader grid's pixel bus into the framebuffer.
module shader_scheduler
  import shader_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8,
  parameter int COORD_BITS   = VOX_COORD_W,
  parameter int PALETTE_BITS = VOX_ID_W,
  parameter int PIXEL_BITS   = 8,
  parameter int VADDR_BITS   = 10,
  parameter int FB_ADDR_BITS = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [VADDR_BITS:0]                num_voxels,
  input  logic [PALETTE_BITS:0]              num_colors,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               voxel_rd,
  output logic [VADDR_BITS-1:0]              voxel_addr,
  input  logic [3*COORD_BITS+PALETTE_BITS-1:0] voxel_rdata,
  output logic                               pal_rd,
  output logic [PALETTE_BITS-1:0]            pal_addr,
  input  logic [PIXEL_BITS-1:0]              pal_rdata,
  output logic [COORD_BITS-1:0]              voxel_x,
  output logic [COORD_BITS-1:0]              voxel_y,
  output logic [COORD_BITS-1:0]              voxel_z,
  output logic [PALETTE_BITS-1:0]            voxel_id,
  output logic [PIXEL_BITS-1:0]              palette_entry,
  output logic                               do_rasterize,
  output logic                               do_shade,
  input  logic                               rasterizing_done,
  input  logic                               shading_done,
  output logic [ROW_BITS-1:0]                row,
  output logic [COL_BITS-1:0]                col,
  input  logic [PIXEL_BITS-1:0]              pixel,
  output logic                               fb_we,
  output logic [FB_ADDR_BITS-1:0]            fb_addr,
  output logic [PIXEL_BITS-1:0]              fb_data
);

  localparam int VCNT_BITS = VADDR_BITS + 1;
  localparam int CCNT_BITS = PALETTE_BITS + 1;
  localparam int IDX_BITS  = (VCNT_BITS > CCNT_BITS) ? VCNT_BITS : CCNT_BITS;

  typedef struct packed {
    voxel_t                vox;
    logic [PIXEL_BITS-1:0] entry;
  } bcast_t;

  sched_state_e          state;
  logic [IDX_BITS-1:0]   idx, last, next2, rd_addr, rd_addr_q;
  logic [VCNT_BITS-1:0]  nvox_q, last_v;
  logic [CCNT_BITS-1:0]  ncol_q, last_c;
  logic                  fetch_step, rd_valid_q;
  logic                  voxel_phase, shade_phase, in_fetch;
  logic                  step_done, advance, at_last, fetch_rd, pref_rd, any_rd;
  bcast_t                cur, cap_d;

  assign last_v      = nvox_q - VCNT_BITS'(1);
  assign last_c      = ncol_q - CCNT_BITS'(1);
  assign voxel_phase = (state == ST_R_FETCH) || (state == ST_RASTER);
  assign shade_phase = (state == ST_S_FETCH) || (state == ST_SHADE);
  assign in_fetch    = (state == ST_R_FETCH) || (state == ST_S_FETCH);
  assign last        = voxel_phase ? IDX_BITS'(last_v) : IDX_BITS'(last_c);
  assign at_last     = (idx == last);
  assign step_done   = ((state == ST_RASTER) && rasterizing_done) ||
                       ((state == ST_SHADE) && shading_done);
  assign advance     = step_done && !at_last;
  assign next2       = idx + IDX_BITS'(2);

  // Reads are issued in the done cycle itself so the data lands before the
  // next done, even at the shortest shade period.
  assign fetch_rd = in_fetch && (!fetch_step || (last != '0));
  assign pref_rd  = advance && ((idx + IDX_BITS'(1)) != last);
  assign any_rd   = fetch_rd || pref_rd;
  assign rd_addr  = fetch_rd ? IDX_BITS'(fetch_step) : next2;

  assign voxel_rd   = voxel_phase && any_rd;
  assign voxel_addr = voxel_rd ? rd_addr[VADDR_BITS-1:0] : '0;
  assign pal_rd     = shade_phase && any_rd;
  assign pal_addr   = pal_rd ? rd_addr[PALETTE_BITS-1:0] : '0;

  assign do_rasterize = (state == ST_RASTER) && !(rasterizing_done && at_last);
  assign do_shade     = (state == ST_SHADE) && !(shading_done && at_last);

  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign fb_we      = (state == ST_READOUT);
  assign fb_addr    = FB_ADDR_BITS'(row) * FB_ADDR_BITS'(COLS) + FB_ADDR_BITS'(col);
  assign fb_data    = fb_we ? pixel : '0;

  // During shading the coordinates stay put; only id and palette entry change.
  always_comb begin
    cap_d = cur;
    if (voxel_phase) begin
      cap_d.vox = voxel_t'(voxel_rdata);
    end else begin
      cap_d.vox.id = rd_addr_q[PALETTE_BITS-1:0];
      cap_d.entry  = pal_rdata;
    end
  end

  bcast_prefetch #(.W($bits(bcast_t))) u_bcast (
    .clock    (clock),
    .reset    (reset),
    .capture  (rd_valid_q),
    .to_bcast (rd_addr_q == '0),
    .advance  (advance),
    .d        (cap_d),
    .bcast    (cur)
  );

  assign voxel_x       = cur.vox.x;
  assign voxel_y       = cur.vox.y;
  assign voxel_z       = cur.vox.z;
  assign voxel_id      = cur.vox.id;
  assign palette_entry = cur.entry;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      fetch_step <= 1'b0;
      nvox_q     <= '0;
      ncol_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      row        <= '0;
      col        <= '0;
    end else begin
      rd_valid_q <= any_rd;
      rd_addr_q  <= rd_addr;
      case (state)
        ST_IDLE: begin
          if (start) begin
            nvox_q     <= num_voxels;
            ncol_q     <= num_colors;
            idx        <= '0;
            fetch_step <= 1'b0;
            if (num_voxels != '0)      state <= ST_R_FETCH;
            else if (num_colors != '0) state <= ST_S_FETCH;
            else                       state <= ST_READOUT;
          end
        end
        ST_R_FETCH, ST_S_FETCH: begin
          fetch_step <= ~fetch_step;
          if (fetch_step) state <= (state == ST_R_FETCH) ? ST_RASTER : ST_SHADE;
        end
        ST_RASTER, ST_SHADE: begin
          if (step_done) begin
            if (at_last) begin
              idx   <= '0;
              state <= ((state == ST_RASTER) && (ncol_q != '0)) ? ST_S_FETCH : ST_READOUT;
            end else begin
              idx <= idx + IDX_BITS'(1);
            end
          end
        end
        ST_READOUT: begin
          if (col == COL_BITS'(COLS - 1)) begin
            col <= '0;
            if (row == ROW_BITS'(ROWS - 1)) begin
              row   <= '0;
              state <= ST_DONE;
            end else begin
              row <= row + ROW_BITS'(1);
            end
          end else begin
            col <= col + COL_BITS'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shader_scheduler.sv
// Directed bench for shader_scheduler with memory, shader and pixel-bus models.
module tb_shader_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] num_voxels = '0;
  logic [8:0]  num_colors = '0;
  logic        busy, frame_done, voxel_rd, pal_rd;
  logic [9:0]  voxel_addr;
  logic [31:0] voxel_rdata = '0;
  logic [7:0]  pal_addr;
  logic [7:0]  pal_rdata = '0;
  logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id, palette_entry;
  logic        do_rasterize, do_shade;
  logic        rasterizing_done = 1'b0;
  logic        shading_done = 1'b0;
  logic [7:0]  row, col, pixel;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;

  int total = 0;
  int bad = 0;
  int nv, nc, rlat;
  int rcnt, scnt;
  int busy_cyc, n_fd, n_vrd, n_prd, n_fb;
  int vseq, pseq, fbseq, ridx, sidx;
  bit in_r, in_s;

  typedef struct {
    int nvox;
    int ncol;
    int rl;
    int exp_busy;
  } vec_t;
  vec_t vecs[6];

  always #5 clock = ~clock;

  shader_scheduler dut (
    .clock(clock), .reset(reset), .start(start),
    .num_voxels(num_voxels), .num_colors(num_colors),
    .busy(busy), .frame_done(frame_done),
    .voxel_rd(voxel_rd), .voxel_addr(voxel_addr), .voxel_rdata(voxel_rdata),
    .pal_rd(pal_rd), .pal_addr(pal_addr), .pal_rdata(pal_rdata),
    .voxel_x(voxel_x), .voxel_y(voxel_y), .voxel_z(voxel_z), .voxel_id(voxel_id),
    .palette_entry(palette_entry),
    .do_rasterize(do_rasterize), .do_shade(do_shade),
    .rasterizing_done(rasterizing_done), .shading_done(shading_done),
    .row(row), .col(col), .pixel(pixel),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  function automatic logic [31:0] vox_word(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b + 8'd1, b + 8'd17, b + 8'd33, b + 8'd49};
  endfunction

  function automatic logic [7:0] pal_word(input int a);
    logic [7:0] b;
    b = 8'(a);
    return b * 8'd7 + 8'd3;
  endfunction

  // Memories with one-cycle read latency; garbage when not read.
  always @(posedge clock) begin
    voxel_rdata <= voxel_rd ? vox_word(int'(voxel_addr)) : 32'hDEAD_BEEF;
    pal_rdata   <= pal_rd ? pal_word(int'(pal_addr)) : 8'hEE;
  end

  assign pixel = 8'((row * 16) + col);

  // Shader grid: done pulses rlat cycles into a raster request, every
  // other cycle while shading.
  always @(posedge clock) begin
    if (reset) begin
      rcnt <= 0;
      scnt <= 0;
      rasterizing_done <= 1'b0;
      shading_done <= 1'b0;
    end else begin
      if (do_rasterize && !rasterizing_done) begin
        if (rcnt == rlat - 1) begin
          rasterizing_done <= 1'b1;
          rcnt <= 0;
        end else rcnt <= rcnt + 1;
      end else rasterizing_done <= 1'b0;
      if (do_shade && !shading_done) begin
        if (scnt == 0) shading_done <= 1'b1;
        else scnt <= scnt + 1;
      end else shading_done <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      ridx = 0; sidx = 0; in_r = 0; in_s = 0;
      vseq = 0; pseq = 0; fbseq = 0;
    end else begin
      busy_cyc += int'(busy);
      n_fd += int'(frame_done);
      if (voxel_rd) begin
        checkOutput("voxel_addr", 64'(voxel_addr), 64'(vseq));
        vseq++; n_vrd++;
      end
      if (pal_rd) begin
        checkOutput("pal_addr", 64'(pal_addr), 64'(pseq));
        pseq++; n_prd++;
      end
      if (fb_we) begin
        checkOutput("fb_addr", 64'(fb_addr), 64'(fbseq));
        checkOutput("fb_data", 64'(fb_data), 64'((fbseq / 4) * 16 + fbseq % 4));
        fbseq++; n_fb++;
      end
      if (do_rasterize) in_r = 1;
      if (in_r) begin
        checkOutput("do_rasterize", 64'(do_rasterize),
                    64'(!(rasterizing_done && ridx == nv - 1)));
        checkOutput("voxel_bcast", 64'({voxel_x, voxel_y, voxel_z, voxel_id}),
                    64'(vox_word(ridx)));
        if (rasterizing_done) begin
          if (ridx == nv - 1) in_r = 0;
          else ridx++;
        end
      end
      if (do_shade) in_s = 1;
      if (in_s) begin
        checkOutput("do_shade", 64'(do_shade), 64'(!(shading_done && sidx == nc - 1)));
        checkOutput("shade_bcast", 64'({voxel_id, palette_entry}),
                    64'({8'(sidx), pal_word(sidx)}));
        if (shading_done) begin
          if (sidx == nc - 1) in_s = 0;
          else sidx++;
        end
      end
    end
  end

  task automatic clearStats();
    busy_cyc = 0; n_fd = 0; n_vrd = 0; n_prd = 0; n_fb = 0;
    vseq = 0; pseq = 0; fbseq = 0; ridx = 0; sidx = 0; in_r = 0; in_s = 0;
  endtask

  task automatic pulseStart(input int nvx, input int ncl, input int rl);
    @(negedge clock);
    nv = nvx; nc = ncl; rlat = rl;
    clearStats();
    num_voxels = 11'(nvx);
    num_colors = 9'(ncl);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitDone(output bit seen);
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (frame_done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) checkOutput("frame_done_timeout", 64'(0), 64'(1));
  endtask

  task automatic applyStimulus(input int nvx, input int ncl, input int rl);
    bit seen;
    pulseStart(nvx, ncl, rl);
    waitDone(seen);
    repeat (2) @(negedge clock);
  endtask

  task automatic checkFrame(input int nvx, input int ncl, input int eb);
    checkOutput("busy_cycles", 64'(busy_cyc), 64'(eb));
    checkOutput("voxel_reads", 64'(n_vrd), 64'(nvx));
    checkOutput("pal_reads", 64'(n_prd), 64'(ncl));
    checkOutput("fb_writes", 64'(n_fb), 64'(16));
    checkOutput("frame_done_count", 64'(n_fd), 64'(1));
    checkOutput("idle_after", 64'(busy), 64'(0));
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_do_r"}, 64'(do_rasterize), 64'(0));
    checkOutput({tag, "_do_s"}, 64'(do_shade), 64'(0));
    checkOutput({tag, "_vrd"}, 64'({voxel_rd, voxel_addr}), 64'(0));
    checkOutput({tag, "_bcast"}, 64'({voxel_x, voxel_y, voxel_z, voxel_id, palette_entry}), 64'(0));
    checkOutput({tag, "_rowcol"}, 64'({row, col}), 64'(0));
    checkOutput({tag, "_fb"}, 64'({fb_we, fb_addr, fb_data, frame_done}), 64'(0));
  endtask

  initial begin
    bit seen;
    // busy = R_FETCH 2 + RASTER n*(rl+1) + S_FETCH 2 + SHADE 2n + READOUT 16 + DONE 1
    vecs[0] = '{nvox: 1, ncol: 1, rl: 3, exp_busy: 27};
    vecs[1] = '{nvox: 3, ncol: 2, rl: 5, exp_busy: 43};
    vecs[2] = '{nvox: 2, ncol: 4, rl: 2, exp_busy: 35};
    vecs[3] = '{nvox: 0, ncol: 3, rl: 3, exp_busy: 25};
    vecs[4] = '{nvox: 2, ncol: 0, rl: 1, exp_busy: 23};
    vecs[5] = '{nvox: 0, ncol: 0, rl: 1, exp_busy: 17};
    nv = 0; nc = 0; rlat = 1;
    clearStats();

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkQuiet("reset");

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].nvox, vecs[v].ncol, vecs[v].rl);
      checkFrame(vecs[v].nvox, vecs[v].ncol, vecs[v].exp_busy);
    end

    // Stray starts mid-frame and in the DONE cycle must be ignored.
    pulseStart(1, 1, 3);
    repeat (8) @(negedge clock);
    num_voxels = 11'd7;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitDone(seen);
    num_voxels = 11'd2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("start_in_done_ignored", 64'(busy), 64'(0));
    @(negedge clock);
    checkOutput("still_idle", 64'(busy), 64'(0));
    checkFrame(1, 1, 27);

    // Reset in the middle of rasterization aborts the frame silently.
    pulseStart(3, 2, 5);
    for (int i = 0; i < 20 && !do_rasterize; i++) @(negedge clock);
    checkOutput("raster_started", 64'(do_rasterize), 64'(1));
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkQuiet("abort");
    n_fd = 0;
    repeat (40) @(negedge clock);
    checkOutput("no_done_after_abort", 64'(n_fd), 64'(0));
    applyStimulus(3, 2, 5);
    checkFrame(3, 2, 43);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
